// File: rtl/savestate_cmd_seq_if.sv
// Handshake bundle between the savestate UI, the core pause control and the
// savestate engine. The sequencer takes the master side.
interface savestate_cmd_seq_if;
    logic       ss_save;
    logic       ss_load;
    logic [1:0] selected_slot;
    logic       pause_ack;
    logic       eng_busy;
    logic       eng_done;
    logic       eng_error;
    logic       pause_req;
    logic       eng_start;
    logic       eng_load;
    logic [1:0] eng_slot;
    logic [3:0] slot_valid;
    logic       seq_busy;
    logic       info_req;
    logic [7:0] info_code;

    modport master (
        input  ss_save, ss_load, selected_slot, pause_ack, eng_busy, eng_done, eng_error,
        output pause_req, eng_start, eng_load, eng_slot, slot_valid, seq_busy, info_req, info_code
    );

    modport slave (
        output ss_save, ss_load, selected_slot, pause_ack, eng_busy, eng_done, eng_error,
        input  pause_req, eng_start, eng_load, eng_slot, slot_valid, seq_busy, info_req, info_code
    );
endinterface

// File: rtl/savestate_cmd_seq.sv
// Savestate command sequencer: pause core, run the engine, resume core,
// track which slots hold valid saves and report outcomes as info codes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a save/load request
// S_PAUSE  | pause_req high, waiting for pause_ack
// S_START  | one-cycle eng_start pulse
// S_ACCEPT | waiting for eng_busy (done/error also accepted here)
// S_RUN    | engine running, waiting for done/error
// S_RESUME | pause_req low, waiting for pause_ack to fall
module savestate_cmd_seq #(
    parameter int unsigned TIMEOUT_BITS = 24,
    parameter logic [7:0]  INFO_BASE    = 8'd16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    savestate_cmd_seq_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_START, S_ACCEPT, S_RUN, S_RESUME
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] WD_MAX = '1;
    localparam logic [TIMEOUT_BITS-1:0] WD_ONE = TIMEOUT_BITS'(1);

    state_t                  state_q, state_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d, wd_inc;
    logic                    op_load_q, op_load_d;
    logic [1:0]              slot_q, slot_d;
    logic [3:0]              slot_valid_q, slot_valid_d;
    logic                    pause_req_q, pause_req_d;
    logic                    eng_start_q, eng_start_d;
    logic                    seq_busy_q, seq_busy_d;
    logic                    info_req_q, info_req_d;
    logic [7:0]              info_code_q, info_code_d;
    logic                    wd_expired, req, outcome;

    // Next-state, watchdog and outcome/info-code decode.
    always_comb begin
        state_d      = state_q;
        op_load_d    = op_load_q;
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        info_req_d   = 1'b0;
        info_code_d  = info_code_q;
        outcome      = 1'b0;
        req          = bus.ss_save | bus.ss_load;
        // Saturating increment; expiry is flagged on the cycle the count would reach max.
        wd_inc       = (wd_q == WD_MAX) ? wd_q : wd_q + WD_ONE;
        wd_expired   = (wd_inc == WD_MAX);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_load_d = ~bus.ss_save;
                    slot_d    = bus.selected_slot;
                    if (!bus.ss_save && !slot_valid_q[bus.selected_slot]) begin
                        info_req_d  = 1'b1;
                        info_code_d = INFO_BASE;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.pause_ack) begin
                    state_d = S_START;
                end else if (wd_expired) begin
                    state_d     = S_RESUME;
                    outcome     = 1'b1;
                    info_code_d = INFO_BASE + 8'd5;
                end
            end
            S_START: state_d = S_ACCEPT;
            S_ACCEPT, S_RUN: begin
                if (bus.eng_error) begin
                    if (!op_load_q) slot_valid_d[slot_q] = 1'b0;
                    state_d     = S_RESUME;
                    outcome     = 1'b1;
                    info_code_d = INFO_BASE + 8'd4;
                end else if (bus.eng_done) begin
                    if (!op_load_q) slot_valid_d[slot_q] = 1'b1;
                    state_d     = S_RESUME;
                    outcome     = 1'b1;
                    info_code_d = op_load_q ? INFO_BASE + 8'd3 : INFO_BASE + 8'd2;
                end else if (wd_expired) begin
                    state_d     = S_RESUME;
                    outcome     = 1'b1;
                    info_code_d = INFO_BASE + 8'd5;
                end else if (state_q == S_ACCEPT && bus.eng_busy) begin
                    state_d = S_RUN;
                end
            end
            S_RESUME: begin
                if (!bus.pause_ack || wd_expired) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (outcome) begin
            info_req_d = 1'b1;
        end else if (state_q != S_IDLE && req) begin
            info_req_d  = 1'b1;
            info_code_d = INFO_BASE + 8'd1;
        end

        if (state_d != state_q)
            wd_d = '0;
        else if (state_q == S_IDLE || state_q == S_START)
            wd_d = '0;
        else
            wd_d = wd_inc;

        pause_req_d = (state_d == S_PAUSE) || (state_d == S_START) ||
                      (state_d == S_ACCEPT) || (state_d == S_RUN);
        eng_start_d = (state_d == S_START);
        seq_busy_d  = (state_d != S_IDLE);
    end

    // All state and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            op_load_q    <= 1'b0;
            slot_q       <= 2'd0;
            slot_valid_q <= 4'd0;
            pause_req_q  <= 1'b0;
            eng_start_q  <= 1'b0;
            seq_busy_q   <= 1'b0;
            info_req_q   <= 1'b0;
            info_code_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            wd_q         <= wd_d;
            op_load_q    <= op_load_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            pause_req_q  <= pause_req_d;
            eng_start_q  <= eng_start_d;
            seq_busy_q   <= seq_busy_d;
            info_req_q   <= info_req_d;
            info_code_q  <= info_code_d;
        end
    end

    assign bus.pause_req  = pause_req_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_load   = op_load_q;
    assign bus.eng_slot   = slot_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.seq_busy   = seq_busy_q;
    assign bus.info_req   = info_req_q;
    assign bus.info_code  = info_code_q;
endmodule
